// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver state encoding and line levels.
// The transmitter imports the same package so both ends agree on framing.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    STOP,
    HANDOFF,
    CLOSE
  } rx_state_e;

  localparam logic MARKING   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL sets the
// level both stages take on reset so the output starts at a known idle value.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/serial_receiver.sv
// Oversampling start/data/stop receiver: samples mid-bit, assembles N bits LSB
// first and hands the word to the consumer over the dav_/rfd four-phase handshake.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         rxd,
  input  logic         rfd,
  output logic [N-1:0] data_out,
  output logic         dav_,
  output logic         ferr,
  output logic         ovr
);

  localparam int WAIT_W  = $clog2(K);
  localparam int COUNT_W = $clog2(N + 1);

  localparam logic [WAIT_W-1:0]  WAIT_HALF  = WAIT_W'(K / 2 - 1);
  localparam logic [WAIT_W-1:0]  WAIT_FULL  = WAIT_W'(K - 1);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(N);

  logic              rxs;
  logic              fall;
  rx_state_e         state_q, state_d;
  logic              rxd_prev_q, rxd_prev_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [N-1:0]      buffer_q, buffer_d;
  logic [N-1:0]      data_q, data_d;
  logic              dav_n_q, dav_n_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  // New bit enters at the MSB so the first (LSB) bit ends up in bit 0 after N shifts.
  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
    logic [N-1:0] r;
    r        = cur >> 1;
    r[N-1]   = b;
    return r;
  endfunction

  bit_sync #(
    .RESET_VAL(MARKING)
  ) u_rxd_sync (
    .clock(clock),
    .reset(reset),
    .d    (rxd),
    .q    (rxs)
  );

  assign fall = (rxd_prev_q == MARKING) && (rxs != MARKING);

  always_comb begin
    state_d    = state_q;
    rxd_prev_d = rxs;
    wait_cnt_d = wait_cnt_q;
    count_d    = count_q;
    buffer_d   = buffer_q;
    data_d     = data_q;
    dav_n_d    = dav_n_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          wait_cnt_d = WAIT_HALF;
          state_d    = START;
        end
      end

      START: begin
        if (wait_cnt_q == '0) begin
          if (rxs == START_BIT) begin
            wait_cnt_d = WAIT_FULL;
            count_d    = COUNT_FULL;
            state_d    = BITS;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      BITS: begin
        if (wait_cnt_q == '0) begin
          buffer_d   = shift_in(buffer_q, rxs);
          count_d    = count_q - COUNT_W'(1);
          wait_cnt_d = WAIT_FULL;
          if (count_q == COUNT_W'(1)) begin
            state_d = STOP;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      STOP: begin
        if (wait_cnt_q == '0) begin
          data_d  = buffer_q;
          ferr_d  = (rxs != STOP_BIT);
          dav_n_d = 1'b0;
          state_d = HANDOFF;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      // The line is not watched for starts until the handshake closes; any start seen here is lost.
      HANDOFF: begin
        if (fall) begin
          ovr_d = 1'b1;
        end
        if (!rfd) begin
          dav_n_d = 1'b1;
          state_d = CLOSE;
        end
      end

      CLOSE: begin
        if (fall) begin
          ovr_d = 1'b1;
        end
        if (rfd) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rxd_prev_q <= MARKING;
      wait_cnt_q <= '0;
      count_q    <= '0;
      data_q     <= '0;
      dav_n_q    <= 1'b1;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxd_prev_q <= rxd_prev_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      data_q     <= data_d;
      dav_n_q    <= dav_n_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Shift register contents are only ever exposed through data_q, so it needs no reset.
  always_ff @(posedge clock) begin
    buffer_q <= buffer_d;
  end

  assign data_out = data_q;
  assign dav_     = dav_n_q;
  assign ferr     = ferr_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver with N = 8, K = 4.
module tb_serial_receiver;

  localparam int N = 8;
  localparam int K = 4;

  logic         clock;
  logic         reset;
  logic         rxd;
  logic         rfd;
  logic [N-1:0] data_out;
  logic         dav_;
  logic         ferr;
  logic         ovr;

  int checks;
  int fails;

  serial_receiver #(
    .N(N),
    .K(K)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rxd     (rxd),
    .rfd     (rfd),
    .data_out(data_out),
    .dav_    (dav_),
    .ferr    (ferr),
    .ovr     (ovr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one full frame; returns one cycle after the stop bit window closes.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    tick(K);
    for (int i = 0; i < N; i++) begin
      rxd = d[i];
      tick(K);
    end
    rxd = stop_bit;
    tick(K);
    rxd = 1'b1;
  endtask

  task automatic handshake(input string tag);
    rfd = 1'b0;
    tick(1);
    check({tag, "_dav_rise"}, {31'd0, dav_}, 32'd1);
    rfd = 1'b1;
    tick(1);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rxd    = 1'b1;
    rfd    = 1'b1;
    reset  = 1'b1;
    tick(3);
    check("rst_dav", {31'd0, dav_}, 32'd1);
    check("rst_data", {24'd0, data_out}, 32'h00);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_ovr", {31'd0, ovr}, 32'd0);
    reset = 1'b0;
    tick(4);

    // Frame 0xA5: stop sample lands one edge after the frame window ends.
    send_frame(8'hA5, 1'b1);
    check("a5_dav_before_stop_sample", {31'd0, dav_}, 32'd1);
    tick(1);
    check("a5_dav_fall", {31'd0, dav_}, 32'd0);
    check("a5_data", {24'd0, data_out}, 32'hA5);
    check("a5_ferr", {31'd0, ferr}, 32'd0);
    tick(5);
    check("a5_dav_held", {31'd0, dav_}, 32'd0);
    check("a5_data_held", {24'd0, data_out}, 32'hA5);
    handshake("a5");
    tick(3);

    // Glitch shorter than half a bit.
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    check("glitch_dav", {31'd0, dav_}, 32'd1);
    check("glitch_ovr", {31'd0, ovr}, 32'd0);
    check("glitch_data", {24'd0, data_out}, 32'hA5);

    // Bad stop bit, then a good frame clears ferr.
    send_frame(8'h3C, 1'b0);
    tick(1);
    check("3c_dav", {31'd0, dav_}, 32'd0);
    check("3c_data", {24'd0, data_out}, 32'h3C);
    check("3c_ferr", {31'd0, ferr}, 32'd1);
    handshake("3c");
    tick(2);
    send_frame(8'h01, 1'b1);
    tick(1);
    check("01_data", {24'd0, data_out}, 32'h01);
    check("01_ferr", {31'd0, ferr}, 32'd0);
    handshake("01");
    tick(2);

    // Overrun: second frame arrives while the first is still pending.
    send_frame(8'h5A, 1'b1);
    tick(1);
    check("ovr_first_dav", {31'd0, dav_}, 32'd0);
    check("ovr_before", {31'd0, ovr}, 32'd0);
    send_frame(8'h99, 1'b1);
    tick(2);
    check("ovr_set", {31'd0, ovr}, 32'd1);
    check("ovr_data_kept", {24'd0, data_out}, 32'h5A);
    check("ovr_dav_still_low", {31'd0, dav_}, 32'd0);
    handshake("ovr");
    tick(3);
    send_frame(8'h55, 1'b1);
    tick(1);
    check("55_data", {24'd0, data_out}, 32'h55);
    check("55_dav", {31'd0, dav_}, 32'd0);
    check("55_ovr_sticky", {31'd0, ovr}, 32'd1);
    handshake("55");
    tick(3);

    // Reset during data bit 3 of a partial frame (bits 1,0,1 then bit 3 = 0).
    rxd = 1'b0;
    tick(K);
    rxd = 1'b1;
    tick(K);
    rxd = 1'b0;
    tick(K);
    rxd = 1'b1;
    tick(K);
    rxd = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rxd   = 1'b1;
    check("midrst_dav", {31'd0, dav_}, 32'd1);
    check("midrst_data", {24'd0, data_out}, 32'h00);
    check("midrst_ferr", {31'd0, ferr}, 32'd0);
    check("midrst_ovr", {31'd0, ovr}, 32'd0);
    tick(40);
    check("midrst_no_partial", {31'd0, dav_}, 32'd1);
    send_frame(8'hFF, 1'b1);
    tick(1);
    check("ff_data", {24'd0, data_out}, 32'hFF);
    check("ff_dav", {31'd0, dav_}, 32'd0);
    handshake("ff");

    // Back-to-back frames with a prompt consumer.
    send_frame(8'h00, 1'b1);
    tick(1);
    check("b2b0_dav", {31'd0, dav_}, 32'd0);
    check("b2b0_data", {24'd0, data_out}, 32'h00);
    handshake("b2b0");
    send_frame(8'h80, 1'b1);
    tick(1);
    check("b2b1_dav", {31'd0, dav_}, 32'd0);
    check("b2b1_data", {24'd0, data_out}, 32'h80);
    check("b2b1_ovr", {31'd0, ovr}, 32'd0);
    check("b2b1_ferr", {31'd0, ferr}, 32'd0);
    handshake("b2b1");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
